// File: rtl/bru_pkg.sv
// Shared types for the branch resolve unit: condition codes, FSM states and
// the payloads carried by the D->E and E->M stage registers.
package bru_pkg;

   localparam int PC_W = 32;

   typedef enum logic [2:0] {
      BEQ  = 3'd0,
      BNE  = 3'd1,
      BLEZ = 3'd2,
      BGTZ = 3'd3,
      BLTZ = 3'd4,
      BGEZ = 3'd5
   } br_op_t;

   typedef enum logic {
      RUN     = 1'b0,
      RECOVER = 1'b1
   } bru_state_t;

   // Payload of the D->E register; its valid bit lives in the valid pipe.
   typedef struct packed {
      logic            pred;
      logic [PC_W-1:0] pc;
      logic [PC_W-1:0] imm;
      br_op_t          op;
   } de_t;

   // Payload of the E->M register; its valid bit lives in the valid pipe.
   typedef struct packed {
      logic            taken;
      logic            pred;
      logic [PC_W-1:0] pc;
      logic [PC_W-1:0] target;
   } em_t;

endpackage

// File: rtl/bru_cond_eval.sv
// Combinational branch condition evaluator. Operands are compared as signed
// 32-bit values; the compare-with-zero ops look only at a.
module bru_cond_eval
   import bru_pkg::*;
(
   input  br_op_t          op,
   input  logic [PC_W-1:0] a,
   input  logic [PC_W-1:0] b,
   output logic            taken
);

   // Decode the condition; undefined encodings resolve to not-taken.
   always_comb begin
      taken = 1'b0;
      case (op)
         BEQ:     taken = (a == b);
         BNE:     taken = (a != b);
         BLEZ:    taken = ($signed(a) <= 0);
         BGTZ:    taken = ($signed(a) > 0);
         BLTZ:    taken = a[PC_W-1];
         BGEZ:    taken = ~a[PC_W-1];
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: carries the fetch-time prediction from D to M,
// resolves the condition in E and drives predictor update/recovery in M.
// A one-cycle RECOVER state masks the wrong-path branch sitting in D right
// after a mispredict. Saturating branch / mispredict statistics.
module branch_resolve_unit
   import bru_pkg::*;
#(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic                 branchD,
   input  logic                 pcsrcPD,
   input  logic [PC_W-1:0]      pcD,
   input  logic [PC_W-1:0]      immD,
   input  br_op_t               bropD,
   input  logic [PC_W-1:0]      srcaE,
   input  logic [PC_W-1:0]      srcbE,
   output logic                 pcsrcM,
   output logic                 pcsrcPM,
   output logic [PC_W-1:0]      fpcM,
   output logic [PC_W-1:0]      pcM,
   output logic                 branchM,
   output logic                 pmis,
   output logic                 flushD,
   output logic                 flushE,
   output logic [CNT_WIDTH-1:0] branch_cnt,
   output logic [CNT_WIDTH-1:0] mis_cnt
);

   localparam int STAGES = 2;

   // vldPipe[1] = E-stage valid, vldPipe[2] = M-stage valid
   logic [STAGES:1]      vldPipe;
   de_t                  deReg;
   em_t                  emReg;
   bru_state_t           state;
   logic                 recover;
   logic                 takenE;
   logic                 mis;
   logic [PC_W-1:0]      targetE;
   logic [CNT_WIDTH-1:0] brCnt;
   logic [CNT_WIDTH-1:0] misCnt;

   assign recover = (state == RECOVER);

   bru_cond_eval uCond (
      .op    (deReg.op),
      .a     (srcaE),
      .b     (srcbE),
      .taken (takenE)
   );

   // Immediate is a word offset; wraps modulo 2^32.
   assign targetE = deReg.pc + PC_W'(4) + (deReg.imm << 2);

   // Stalled cycles never report a mispredict, so a held branch pulses once.
   assign mis     = vldPipe[2] & (emReg.taken ^ emReg.pred) & ~stall;
   assign pmis    = mis;
   assign flushD  = mis;
   assign flushE  = mis;

   assign branchM = vldPipe[2];
   assign pcsrcM  = emReg.taken;
   assign pcsrcPM = emReg.pred;
   assign pcM     = emReg.pc;
   assign fpcM    = emReg.taken ? emReg.target : emReg.pc + PC_W'(4);

   assign branch_cnt = brCnt;
   assign mis_cnt    = misCnt;

   // Stage registers: valid bits are killed by RECOVER, flushE and pmis.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vldPipe <= '0;
         deReg   <= '0;
         emReg   <= '0;
      end else if (!stall) begin
         vldPipe[1] <= branchD & ~recover & ~flushE;
         vldPipe[2] <= vldPipe[1] & ~mis;
         deReg      <= '{pred: pcsrcPD, pc: pcD, imm: immD, op: bropD};
         emReg      <= '{taken: takenE, pred: deReg.pred, pc: deReg.pc, target: targetE};
      end
   end

   // RUN/RECOVER: one unstalled cycle of D masking after each mispredict.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= RUN;
      end else if (!stall) begin
         case (state)
            RUN:     if (mis) state <= RECOVER;
            RECOVER: state <= RUN;
            default: state <= RUN;
         endcase
      end
   end

   // Saturating statistics; both hold while stalled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         brCnt  <= '0;
         misCnt <= '0;
      end else if (!stall) begin
         if (vldPipe[2] && brCnt != '1) brCnt <= brCnt + 1'b1;
         if (mis && misCnt != '1)       misCnt <= misCnt + 1'b1;
      end
   end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Resolves conditional branches and reports outcomes back to the tournament branch predictor. It sits on the execute/memory boundary of the 5-stage MIPS pipeline. The unit carries the fetch-time prediction down the pipe, evaluates the real condition in E, and registers the outcome into M. In M it drives the predictor's update/recovery inputs: true direction, predicted direction, corrected PC, branch-valid and mispredict. It also keeps saturating branch and mispredict statistics.

## Interface
- `CNT_WIDTH`, 16: width of the statistics counters.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; asynchronous, active-low.
- `stall`  in  1  pipeline hold; freezes all stage registers.
- `branchD`  in  1  D-stage instruction is a conditional branch.
- `pcsrcPD`  in  1  prediction that travelled with the D-stage instruction.
- `pcD`  in  32  D-stage PC.
- `immD`  in  32  sign-extended branch offset (words).
- `bropD`  in  3  condition, `bru_pkg::br_op_t`: BEQ, BNE, BLEZ, BGTZ, BLTZ, BGEZ.
- `srcaE`, `srcbE`  in  32 each  forwarded E-stage operands.
- `pcsrcM`  out  1  true direction (1 = taken).
- `pcsrcPM`  out  1  predicted direction.
- `fpcM`  out  32  correct next PC after the branch.
- `pcM`  out  32  branch PC.
- `branchM`  out  1  M holds a valid branch.
- `pmis`  out  1  mispredict pulse.
- `flushD`  out  1  kill younger work in the F→D register.
- `flushE`  out  1  kill younger work in the D→E register.
- `branch_cnt`  out  CNT_WIDTH  branches resolved.
- `mis_cnt`  out  CNT_WIDTH  mispredicts.

## Operation
- **D→E register.** Captures `{branchD & ~recover, pcsrcPD, pcD, immD, bropD}`.
  - If `flushE` is high, the captured valid bit is cleared.
- **E stage.**
  - `takenE = bru_cond_eval(bropE, srcaE, srcbE)`, using a signed compare.
  - BLEZ, BGTZ, BLTZ and BGEZ ignore `srcbE`.
  - `targetE = pcE + 4 + (immE << 2)`, modulo 2^32.
- **E→M register.** Captures valid, `takenE`, prediction, `pcE` and `targetE`.
  - If `pmis` is high, the captured valid bit is cleared, because the E instruction is younger than the mispredicted branch.
- **M-stage outputs.**
  - `branchM` = registered valid.
  - `pcsrcM` = registered taken.
  - `pcsrcPM` = registered prediction.
  - `fpcM = pcsrcM ? targetM : pcM + 4`.
  - `pmis = branchM & (pcsrcM ^ pcsrcPM) & ~stall`.
  - `flushD = flushE = pmis`.
- **FSM, states RUN and RECOVER.**
  - RUN → RECOVER when `pmis` is high.
  - RECOVER → RUN after one unstalled cycle.
  - In RECOVER, `recover = 1`, which masks `branchD`: the instruction in D is wrong-path or a bubble.
- **Counters.**
  - `branch_cnt` increments when `branchM & ~stall`.
  - `mis_cnt` increments when `pmis` is high.
  - Both saturate at all-ones and never wrap.
- **Stall.** With `stall` high, all stage registers, the FSM and the counters hold.
  - `pmis` is masked, so a held mispredicting branch pulses exactly once, on its first unstalled cycle.
- **Non-branch instructions** do not affect any predictor-update output other than through `branchM = 0`.
  - `pcsrcM`, `pcsrcPM` and `fpcM` are don't-care for the predictor, but still follow the register contents.

## Timing
- Reset values: all stage registers 0, state RUN, all outputs 0, `fpcM = 4`.
  - `fpcM = 4` because `pcM + 4` with `pcM = 0`.
- Reset is asynchronous assert with synchronous deassert, handled externally. Asserting reset mid-operation discards all in-flight branches immediately.
- Latency: a branch in D at cycle t (no stalls) appears in M at t+2. `pmis` is combinational in cycle t+2 from the M registers.
- The predictor consumes `pmis` combinationally as its `flushE`. The redirect to `fpcM` takes effect at the t+2→t+3 edge.
- **Back-to-back branches:** the second branch, in E while the first mispredicts in M, is killed and never counted.
- **Branch arriving in D during RECOVER** is dropped; a correctly fetched branch reaches D one cycle later and is processed.
- **Simultaneous `pmis` and `stall`:** `stall` wins; `pmis` is deferred.

## Structure
- `bru_pkg` holds:
  - `br_op_t` (3-bit enum of the six conditions);
  - `PC_W = 32`;
  - state enum `bru_state_t {RUN, RECOVER}`.
- One sub-module, `bru_cond_eval`: purely combinational condition evaluator with inputs `op`, `a`, `b` and output `taken`.
- The remainder is a single sequential module: stage registers, FSM and counters.

## Test plan
- **Correct taken prediction:** BEQ with pcD=0x100, imm=3, srca=srcb=5, pcsrcPD=1 → at t+2: branchM=1, pcsrcM=1, fpcM=0x110, pmis=0, branch_cnt=1, mis_cnt=0.
- **Mispredict not-taken:** BNE with pcD=0x200, srca=srcb=7, pcsrcPD=1 → pcsrcM=0, fpcM=0x204, single-cycle pmis=flushD=flushE=1, mis_cnt=1, next cycle state RECOVER.
- **Kill younger branch:** BGTZ srca=1 predicted 0 at t, then BLTZ at t+1 → first branch mispredicts; second never reaches branchM; branch_cnt=1.
- **Stall over mispredict:** stall=1 for 3 cycles while the mispredicting branch sits in M → pmis=0 throughout the stall, then exactly one pulse when stall drops; counters +1 once.
- **Reset mid-flight:** rst low asynchronously while a branch is in E → all outputs 0 (fpcM=4) within the same cycle; after release, no stale branchM.
- **Saturation:** CNT_WIDTH=4 with 20 mispredicting branches → branch_cnt=mis_cnt=0xF; signed BLEZ srca=0x80000000 evaluates taken.
